// File: rtl/mem_rmw_adapter.sv
// Byte-strobe adapter in front of a word-write-only memory port.
// Partial stores become read-modify-write; word reads and full stores pass straight through.
module mem_rmw_adapter #(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_mem_req,
    input  logic              s_mem_we,
    input  logic [XLEN-1:0]   s_mem_addr,
    input  logic [XLEN-1:0]   s_mem_wdata,
    input  logic [STRB_W-1:0] s_mem_wstrb,
    output logic              s_mem_ready,
    output logic [XLEN-1:0]   s_mem_rdata,
    output logic              m_mem_req,
    output logic              m_mem_we,
    output logic [XLEN-1:0]   m_mem_addr,
    output logic [XLEN-1:0]   m_mem_wdata,
    input  logic              m_mem_ready,
    input  logic [XLEN-1:0]   m_mem_rdata,
    output logic              rmw_busy
);

    // Handshake: an upstream request is held stable until s_mem_ready is seen high;
    // a downstream request completes in any cycle where m_mem_req and m_mem_ready are both high.

    typedef enum logic {
        IDLE     = 1'b0,
        MERGE_WR = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] merge_q, merge_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] addr_aligned;
    logic [XLEN-1:0] lane_merge;
    logic            is_full, is_null;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            merge_q <= '0;
            addr_q  <= '0;
        end else begin
            state   <= state_next;
            merge_q <= merge_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        addr_aligned = s_mem_addr & ~(XLEN'(3));
        is_full      = (s_mem_wstrb == '1);
        is_null      = (s_mem_wstrb == '0);
        lane_merge   = '0;
        for (int k = 0; k < STRB_W; k++) begin
            lane_merge[8*k +: 8] = s_mem_wstrb[k] ? s_mem_wdata[8*k +: 8] : m_mem_rdata[8*k +: 8];
        end
    end

    always_comb begin
        state_next  = state;
        merge_d     = merge_q;
        addr_d      = addr_q;
        s_mem_ready = 1'b0;
        s_mem_rdata = '0;
        m_mem_req   = 1'b0;
        m_mem_we    = 1'b0;
        m_mem_addr  = '0;
        m_mem_wdata = '0;
        rmw_busy    = 1'b0;
        // Outputs are forced low while reset is held, even with an upstream request pending.
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (s_mem_req && s_mem_we && is_null) begin
                        s_mem_ready = 1'b1;
                    end else if (s_mem_req && s_mem_we && !is_full) begin
                        m_mem_req  = 1'b1;
                        m_mem_addr = addr_aligned;
                        if (m_mem_ready) begin
                            merge_d    = lane_merge;
                            addr_d     = addr_aligned;
                            state_next = MERGE_WR;
                        end
                    end else begin
                        m_mem_req   = s_mem_req;
                        m_mem_we    = s_mem_we;
                        m_mem_addr  = addr_aligned;
                        m_mem_wdata = s_mem_wdata;
                        s_mem_ready = m_mem_ready;
                        s_mem_rdata = s_mem_we ? s_mem_wdata : m_mem_rdata;
                    end
                end
                MERGE_WR: begin
                    // Driven from registers only so a stalled write cannot glitch.
                    m_mem_req   = 1'b1;
                    m_mem_we    = 1'b1;
                    m_mem_addr  = addr_q;
                    m_mem_wdata = merge_q;
                    rmw_busy    = 1'b1;
                    if (m_mem_ready) begin
                        s_mem_ready = s_mem_req;
                        s_mem_rdata = merge_q;
                        state_next  = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rmw_adapter.sv
// Self-checking bench for mem_rmw_adapter: directed cases, a stall case,
// reset during the merge write, and randomized traffic against a word-level memory model.
module tb_mem_rmw_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_mem_req, s_mem_we, s_mem_ready;
    logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
    logic [3:0]  s_mem_wstrb;
    logic        m_mem_req, m_mem_we, m_mem_ready, rmw_busy;
    logic [31:0] m_mem_addr, m_mem_wdata, m_mem_rdata;

    always #5 clk = ~clk;

    mem_rmw_adapter #(.XLEN(32), .STRB_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_mem_req(s_mem_req), .s_mem_we(s_mem_we), .s_mem_addr(s_mem_addr),
        .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb),
        .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
        .m_mem_req(m_mem_req), .m_mem_we(m_mem_we), .m_mem_addr(m_mem_addr),
        .m_mem_wdata(m_mem_wdata), .m_mem_ready(m_mem_ready), .m_mem_rdata(m_mem_rdata),
        .rmw_busy(rmw_busy)
    );

    // Downstream memory: ready after stall_n wait cycles per access; block_wr withholds write ready.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    int          stall_n = 0;
    logic        block_wr = 1'b0;
    logic        mem_clear;
    int          wait_cnt = 0;
    int          hs_cnt = 0, wr_cnt = 0, busy_cycles = 0;
    int          unstable_cnt = 0, misalign_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [64:0] snap = '0;

    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    function automatic logic [31:0] init_word(int i);
        return 32'(i) * 32'h9E3779B9 + 32'h01234567;
    endfunction

    always_comb begin
        m_mem_ready = m_mem_req && (wait_cnt >= stall_n) && !(block_wr && m_mem_we);
        m_mem_rdata = mem[m_mem_addr[9:2]];
    end

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (m_mem_req && m_mem_ready && m_mem_we) begin
            mem[m_mem_addr[9:2]] <= m_mem_wdata;
        end
        if (m_mem_req && m_mem_ready) begin
            hs_cnt   <= hs_cnt + 1;
            wait_cnt <= 0;
            if (m_mem_we) wr_cnt <= wr_cnt + 1;
        end else if (m_mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
        if (m_mem_req && m_mem_addr[1:0] != 2'b00) misalign_cnt <= misalign_cnt + 1;
        if (rmw_busy) busy_cycles <= busy_cycles + 1;
        if (prev_stall && m_mem_req && ({m_mem_we, m_mem_addr, m_mem_wdata} != snap))
            unstable_cnt <= unstable_cnt + 1;
        prev_stall <= m_mem_req && !m_mem_ready;
        snap       <= {m_mem_we, m_mem_addr, m_mem_wdata};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        else pass_cnt++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the acknowledged cycle (or the cycle budget).
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output int cycles, output logic acked);
        s_mem_req = 1'b1; s_mem_we = we; s_mem_addr = addr;
        s_mem_wdata = wdata; s_mem_wstrb = strb;
        cycles = 0; acked = 1'b0; rdata = '0;
        while (!acked && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (s_mem_ready) begin
                acked = 1'b1;
                rdata = s_mem_rdata;
            end
            @(posedge clk); #1;
        end
        s_mem_req = 1'b0; s_mem_we = 1'b0; s_mem_wstrb = '0;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int stall);
        logic [31:0] old_w, new_w, exp_rd, rd;
        int          exp_cyc, exp_hs, exp_wr, exp_busy, cyc, hs0, wr0, busy0;
        logic        acked;
        int          idx;
        idx   = int'(addr[9:2]);
        old_w = ref_mem[idx];
        new_w = old_w;
        if (!we) begin
            exp_rd = old_w; exp_cyc = 1 + stall; exp_hs = 1; exp_wr = 0; exp_busy = 0;
        end else if (strb == 4'hF) begin
            new_w = wdata; exp_rd = wdata; exp_cyc = 1 + stall; exp_hs = 1; exp_wr = 1; exp_busy = 0;
        end else if (strb == 4'h0) begin
            exp_rd = '0; exp_cyc = 1; exp_hs = 0; exp_wr = 0; exp_busy = 0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) new_w[8*k +: 8] = wdata[8*k +: 8];
            exp_rd = new_w; exp_cyc = 2 + 2 * stall; exp_hs = 2; exp_wr = 1; exp_busy = 1 + stall;
        end
        stall_n = stall;
        hs0 = hs_cnt; wr0 = wr_cnt; busy0 = busy_cycles;
        access(we, addr, wdata, strb, rd, cyc, acked);
        ref_mem[idx] = new_w;
        check("ack", 32'(acked), 32'd1);
        check("rdata", rd, exp_rd);
        check("latency", 32'(cyc), 32'(exp_cyc));
        check("ds_accesses", 32'(hs_cnt - hs0), 32'(exp_hs));
        check("ds_writes", 32'(wr_cnt - wr0), 32'(exp_wr));
        check("busy_cycles", 32'(busy_cycles - busy0), 32'(exp_busy));
        check("mem_word", mem[idx], new_w);
    endtask

    initial begin
        int n;
        logic [3:0] strb;
        rst_n = 1'b0; mem_clear = 1'b1;
        s_mem_req = 1'b0; s_mem_we = 1'b0; s_mem_addr = '0; s_mem_wdata = '0; s_mem_wstrb = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(s_mem_ready), 32'd0);
        check("rst_m_req", 32'(m_mem_req), 32'd0);
        check("rst_m_we", 32'(m_mem_we), 32'd0);
        check("rst_busy", 32'(rmw_busy), 32'd0);
        mem_clear = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b1, 32'h100, 32'h11223344, 4'hF, 0);
        run_txn(1'b0, 32'h100, 32'h0, 4'h0, 0);
        run_txn(1'b1, 32'h104, 32'hDEADBEEF, 4'hF, 0);
        run_txn(1'b0, 32'h104, 32'h0, 4'h0, 0);
        run_txn(1'b1, 32'h102, 32'h00AB0000, 4'b0100, 0);
        check("sb_word", ref_mem[32'h100 >> 2], 32'h11AB3344);
        run_txn(1'b0, 32'h100, 32'h0, 4'h0, 0);
        run_txn(1'b1, 32'h106, 32'hCAFE0000, 4'b1100, 0);
        check("sh_word", ref_mem[32'h104 >> 2], 32'hCAFEBEEF);
        run_txn(1'b1, 32'h104, 32'h12345678, 4'h0, 0);
        run_txn(1'b0, 32'h104, 32'h0, 4'h0, 0);
        run_txn(1'b1, 32'h101, 32'h00005500, 4'b0010, 2);
        run_txn(1'b0, 32'h100, 32'h0, 4'h0, 2);

        // Reset while the merge write is stalled downstream.
        stall_n = 0; block_wr = 1'b1;
        s_mem_req = 1'b1; s_mem_we = 1'b1; s_mem_addr = 32'h108;
        s_mem_wdata = 32'h000000AA; s_mem_wstrb = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rmw_busy && n < 10);
        check("busy_reached", 32'(rmw_busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_s_ready", 32'(s_mem_ready), 32'd0);
        check("arst_m_req", 32'(m_mem_req), 32'd0);
        check("arst_m_we", 32'(m_mem_we), 32'd0);
        check("arst_busy", 32'(rmw_busy), 32'd0);
        s_mem_req = 1'b0; s_mem_we = 1'b0; s_mem_wstrb = '0;
        repeat (2) @(posedge clk);
        block_wr = 1'b0;
        @(negedge clk);
        check("arst_word", mem[32'h108 >> 2], ref_mem[32'h108 >> 2]);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 32'h108, 32'h0, 4'h0, 0);

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0: strb = 4'hF;
                1: strb = 4'h0;
                default: strb = 4'($urandom_range(0, 15));
            endcase
            run_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), $urandom,
                    strb, $urandom_range(0, 2));
        end

        check("stable_when_stalled", 32'(unstable_cnt), 32'd0);
        check("aligned_addr", 32'(misalign_cnt), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
